// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM GHASH datapath.
package gcm_pkg;

    // GCM-native bit order: index 0 is the x^0 coefficient.
    typedef logic [0:127] block_t;

    // Reduction constant: 0xE1 followed by 120 zero bits.
    localparam block_t GCM_R = {8'hE1, 120'h0};

    // Command opcodes; 2'b11 is reserved.
    typedef enum logic [1:0] {
        OP_INIT  = 2'b00,
        OP_BLOCK = 2'b01,
        OP_FINAL = 2'b10
    } ghash_op_e;

    // Engine state.
    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_e;

endpackage

// File: rtl/gf128_mult_digit.sv
// One digit slice of the bit-serial GF(2^128) multiply: consumes DIGIT_W bits of X.
module gf128_mult_digit
    import gcm_pkg::*;
#(
    parameter int unsigned DIGIT_W = 8
) (
    input  block_t               i_z,
    input  block_t               i_v,
    input  logic [0:DIGIT_W-1]   i_x,
    output block_t               o_z,
    output block_t               o_v
);

    block_t z_c;
    block_t v_c;

    // Apply DIGIT_W conditional-accumulate / shift-reduce steps in index order.
    always_comb begin
        z_c = i_z;
        v_c = i_v;
        for (int i = 0; i < int'(DIGIT_W); i++) begin
            if (i_x[i]) begin
                z_c = z_c ^ v_c;
            end
            if (v_c[127]) begin
                v_c = (v_c >> 1) ^ GCM_R;
            end else begin
                v_c = v_c >> 1;
            end
        end
    end

    assign o_z = z_c;
    assign o_v = v_c;

endmodule

// File: rtl/gcm_ghash_mc.sv
// Multi-channel GHASH engine: per-channel H/Y contexts sharing one digit-serial multiplier.
module gcm_ghash_mc
    import gcm_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DIGIT_W = 8,
    parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [CH_W-1:0] i_ch,
    input  block_t          i_block,
    input  block_t          i_mask,
    output logic            o_tag_valid,
    output block_t          o_tag,
    output logic [CH_W-1:0] o_tag_ch,
    output logic            o_err
);

    localparam int unsigned NUM_DIG = 128 / DIGIT_W;
    localparam int unsigned CNT_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIG - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    block_t            x_q, x_d;
    block_t            v_q, v_d;
    block_t            z_q, z_d;
    block_t            mask_q, mask_d;
    block_t            tag_q, tag_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W-1:0]   tag_ch_q, tag_ch_d;
    logic              fin_q, fin_d;
    logic              tag_valid_q, tag_valid_d;
    logic              err_q, err_d;
    logic [NUM_CH-1:0] chv_q, chv_d;

    block_t            h_q [NUM_CH];
    block_t            y_q [NUM_CH];

    logic              h_we_c;
    logic              y_we_c;
    logic [CH_W-1:0]   ctx_ch_c;
    block_t            y_wdata_c;
    block_t            mul_z_c;
    block_t            mul_v_c;
    logic              in_range_c;

    gf128_mult_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_mult (
        .i_z (z_q),
        .i_v (v_q),
        .i_x (x_q[0:DIGIT_W-1]),
        .o_z (mul_z_c),
        .o_v (mul_v_c)
    );

    assign in_range_c = {1'b0, i_ch} < (CH_W + 1)'(NUM_CH);

    // Command decode, multiply sequencing and context write-back selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        v_d         = v_q;
        z_d         = z_q;
        mask_d      = mask_q;
        tag_d       = tag_q;
        ch_d        = ch_q;
        tag_ch_d    = tag_ch_q;
        fin_d       = fin_q;
        chv_d       = chv_q;
        tag_valid_d = 1'b0;
        err_d       = 1'b0;
        h_we_c      = 1'b0;
        y_we_c      = 1'b0;
        ctx_ch_c    = i_ch;
        y_wdata_c   = '0;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if ((i_op == OP_INIT) && in_range_c) begin
                        h_we_c      = 1'b1;
                        y_we_c      = 1'b1;
                        chv_d[i_ch] = 1'b1;
                    end else if (((i_op == OP_BLOCK) || (i_op == OP_FINAL))
                                 && in_range_c && chv_q[i_ch]) begin
                        x_d     = y_q[i_ch] ^ i_block;
                        v_d     = h_q[i_ch];
                        z_d     = '0;
                        ch_d    = i_ch;
                        fin_d   = (i_op == OP_FINAL);
                        mask_d  = i_mask;
                        cnt_d   = '0;
                        state_d = MULT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MULT: begin
                z_d   = mul_z_c;
                v_d   = mul_v_c;
                x_d   = x_q << DIGIT_W;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    y_we_c    = 1'b1;
                    ctx_ch_c  = ch_q;
                    y_wdata_c = mul_z_c;
                    state_d   = IDLE;
                    if (fin_q) begin
                        tag_d        = mul_z_c ^ mask_q;
                        tag_ch_d     = ch_q;
                        tag_valid_d  = 1'b1;
                        chv_d[ch_q]  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            v_q         <= '0;
            z_q         <= '0;
            mask_q      <= '0;
            tag_q       <= '0;
            ch_q        <= '0;
            tag_ch_q    <= '0;
            fin_q       <= 1'b0;
            tag_valid_q <= 1'b0;
            err_q       <= 1'b0;
            chv_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            v_q         <= v_d;
            z_q         <= z_d;
            mask_q      <= mask_d;
            tag_q       <= tag_d;
            ch_q        <= ch_d;
            tag_ch_q    <= tag_ch_d;
            fin_q       <= fin_d;
            tag_valid_q <= tag_valid_d;
            err_q       <= err_d;
            chv_q       <= chv_d;
        end
    end

    // Context storage; contents are qualified by chv_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (h_we_c) begin
            h_q[ctx_ch_c] <= i_block;
        end
        if (y_we_c) begin
            y_q[ctx_ch_c] <= y_wdata_c;
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_tag_valid = tag_valid_q;
    assign o_tag       = tag_q;
    assign o_tag_ch    = tag_ch_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_gcm_ghash_mc.sv
// Scoreboard bench for gcm_ghash_mc: NIST vectors, interleave, errors, reset abort, random traffic.
module tb_gcm_ghash_mc;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned DIGIT_W = 8;
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          L       = 128 / DIGIT_W;

    typedef logic [0:127] blk_t;
    typedef struct {
        bit   is_err;
        blk_t tag;
        int   ch;
    } exp_t;

    logic            clk;
    logic            i_rst_n;
    logic            i_valid;
    logic            o_ready;
    logic [1:0]      i_op;
    logic [CH_W-1:0] i_ch;
    blk_t            i_block;
    blk_t            i_mask;
    logic            o_tag_valid;
    blk_t            o_tag;
    logic [CH_W-1:0] o_tag_ch;
    logic            o_err;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    blk_t mh [NUM_CH];
    blk_t my [NUM_CH];
    bit   mv [NUM_CH];
    blk_t tag_by_ch [NUM_CH];

    blk_t h_tc   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    blk_t c_tc2  = 128'h0388dace60b6a392f328c2b971b2fe78;
    blk_t len2   = 128'h00000000000000000000000000000080;
    blk_t mask_t = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    blk_t tag2   = 128'hab6e47d42cec13bdf53a67b21257bddf;
    blk_t zero_b = '0;

    gcm_ghash_mc #(
        .NUM_CH  (NUM_CH),
        .DIGIT_W (DIGIT_W),
        .CH_W    (CH_W)
    ) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op        (i_op),
        .i_ch        (i_ch),
        .i_block     (i_block),
        .i_mask      (i_mask),
        .o_tag_valid (o_tag_valid),
        .o_tag       (o_tag),
        .o_tag_ch    (o_tag_ch),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference GF(2^128) product, whole-block form.
    function automatic blk_t gmul(input blk_t a, input blk_t b);
        blk_t z = '0;
        blk_t v = b;
        blk_t r = {8'he1, 120'h0};
        for (int i = 0; i < 128; i++) begin
            if (a[i]) z = z ^ v;
            v = v[127] ? ((v >> 1) ^ r) : (v >> 1);
        end
        return z;
    endfunction

    task automatic chk_blk(input string nm, input blk_t act, input blk_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Issue one command, update the model, push expectations, and check busy duration.
    task automatic send(input int op, input int ch, input blk_t blk, input blk_t msk);
        int   n;
        int   busy;
        int   exp_busy;
        blk_t s;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout before op=%0d ch=%0d", op, ch);
        end
        exp_busy = 0;
        if (op == 0) begin
            mh[ch] = blk;
            my[ch] = '0;
            mv[ch] = 1'b1;
        end else if (op == 3 || !mv[ch]) begin
            e.is_err = 1'b1;
            e.tag    = '0;
            e.ch     = ch;
            exp_q.push_back(e);
        end else begin
            s        = gmul(my[ch] ^ blk, mh[ch]);
            my[ch]   = s;
            exp_busy = L;
            if (op == 2) begin
                e.is_err = 1'b0;
                e.tag    = s ^ msk;
                e.ch     = ch;
                exp_q.push_back(e);
                mv[ch] = 1'b0;
            end
        end
        i_valid = 1'b1;
        i_op    = 2'(op);
        i_ch    = CH_W'(ch);
        i_block = blk;
        i_mask  = msk;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        busy = 0;
        n    = 0;
        @(negedge clk);
        while (!o_ready && n < 1000) begin
            busy++;
            @(negedge clk);
            n++;
        end
        chk_int("busy_cycles", busy, exp_busy);
    endtask

    // Monitor: every output strobe must match the head of the expectation queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_rst_n && (o_tag_valid || o_err)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output tag_valid=%0b err=%0b", o_tag_valid, o_err);
                end else begin
                    e = exp_q.pop_front();
                    chk_int("out_kind_err", 32'(o_err), 32'(e.is_err));
                    chk_int("out_kind_tag", 32'(o_tag_valid), 32'(!e.is_err));
                    if (!e.is_err) begin
                        chk_blk("tag_value", o_tag, e.tag);
                        chk_int("tag_ch", 32'(o_tag_ch), 32'(e.ch));
                        if (e.ch < int'(NUM_CH)) tag_by_ch[e.ch] = o_tag;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : stim
        int r;
        int op;
        blk_t b, m;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_op    = '0;
        i_ch    = '0;
        i_block = '0;
        i_mask  = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            mv[c] = 1'b0;
            my[c] = '0;
            mh[c] = '0;
            tag_by_ch[c] = '0;
        end
        repeat (3) @(negedge clk);
        chk_int("rst_ready", 32'(o_ready), 32'd1);
        chk_int("rst_tag_valid", 32'(o_tag_valid), 32'd0);
        chk_int("rst_err", 32'(o_err), 32'd0);
        chk_blk("rst_tag", o_tag, zero_b);
        chk_int("rst_tag_ch", 32'(o_tag_ch), 32'd0);
        i_rst_n = 1'b1;

        // NIST TC2 on channel 0
        send(0, 0, h_tc, zero_b);
        send(1, 0, c_tc2, zero_b);
        send(2, 0, len2, mask_t);
        chk_blk("tc2_tag", tag_by_ch[0], tag2);

        // NIST TC1 on channel 3
        send(0, 3, h_tc, zero_b);
        send(2, 3, zero_b, mask_t);
        chk_blk("tc1_tag", tag_by_ch[3], mask_t);

        // Interleave TC2 on ch0 with TC1 on ch1
        tag_by_ch[0] = '0;
        tag_by_ch[1] = '0;
        send(0, 0, h_tc, zero_b);
        send(0, 1, h_tc, zero_b);
        send(1, 0, c_tc2, zero_b);
        send(2, 1, zero_b, mask_t);
        send(2, 0, len2, mask_t);
        chk_blk("il_tc1_tag", tag_by_ch[1], mask_t);
        chk_blk("il_tc2_tag", tag_by_ch[0], tag2);

        // Errors: uninitialised channel, then FINAL on a closed channel
        send(1, 2, c_tc2, zero_b);
        send(2, 0, len2, mask_t);
        send(3, 0, c_tc2, zero_b);
        chk_blk("tag_hold", o_tag, tag2);

        // Reset in the middle of a multiply
        send(0, 0, h_tc, zero_b);
        @(negedge clk);
        i_valid = 1'b1;
        i_op    = 2'd1;
        i_ch    = '0;
        i_block = c_tc2;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(negedge clk);
        i_rst_n = 1'b0;
        #1;
        chk_int("midrst_ready", 32'(o_ready), 32'd1);
        chk_int("midrst_tag_valid", 32'(o_tag_valid), 32'd0);
        for (int c = 0; c < int'(NUM_CH); c++) mv[c] = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        send(1, 0, c_tc2, zero_b);

        // Randomised traffic against the model
        for (int k = 0; k < 200; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      op = 0;
            else if (r < 7) op = 1;
            else if (r < 9) op = 2;
            else            op = 3;
            b = {$urandom, $urandom, $urandom, $urandom};
            m = {$urandom, $urandom, $urandom, $urandom};
            send(op, int'($urandom_range(0, NUM_CH - 1)), b, m);
        end

        repeat (L + 5) @(negedge clk);
        chk_int("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
